// File: rtl/pov_column_fetcher.sv
// pov_column_fetcher: maps (angle, LED index) to a texture-ROM address and returns pixels with 3-cycle latency.
// Define POV_BRIGHTNESS_EN to scale each colour channel by (brightness+1)/256.
module pov_column_fetcher #(
  parameter int LED_COUNT  = 52,
  parameter int TEX_WIDTH  = 256,
  parameter int THETA_BITS = 6,
  parameter int NUM_FRAMES = 4,
  parameter int FRAME_DIV  = 8,
  parameter int PX_W       = $clog2(LED_COUNT),
  parameter int COL_W      = $clog2(TEX_WIDTH),
  parameter int ADDR_W     = $clog2(NUM_FRAMES*LED_COUNT*TEX_WIDTH),
  parameter int FI_W       = NUM_FRAMES > 1 ? $clog2(NUM_FRAMES) : 1
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic [THETA_BITS-1:0] theta_i,
  input  logic                  rev_pulse_i,
  input  logic                  frame_start_i,
  input  logic                  px_req_i,
  input  logic [PX_W-1:0]       px_idx_i,
  input  logic [COL_W-1:0]      col_offset_i,
  input  logic [7:0]            brightness_i,
  output logic [ADDR_W-1:0]     rom_addr_o,
  input  logic [23:0]           rom_data_i,
  output logic                  px_valid_o,
  output logic [23:0]           px_data_o,
  output logic [FI_W-1:0]       frame_idx_o
);
  localparam int RC_W = FRAME_DIV > 1 ? $clog2(FRAME_DIV) : 1;
  localparam logic [ADDR_W-1:0] FRAME_SZ = ADDR_W'(LED_COUNT*TEX_WIDTH);
  logic [COL_W-1:0] col_q, col_d;
  logic [RC_W-1:0] rev_q, rev_d;
  logic [FI_W-1:0] frame_q, frame_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [23:0] data_q, data_d, scaled;
  logic [THETA_BITS+COL_W-1:0] prod;
  logic [PX_W-1:0] idx_c;
  logic v1_q, oob1_q, v2_q, oob2_q, valid_q, oob_c, rev_wrap;
`ifdef POV_BRIGHTNESS_EN
  function automatic logic [7:0] scl(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] p;
    p = {8'd0, c} * ({8'd0, b} + 16'd1);
    return p[15:8];
  endfunction
  assign scaled = {scl(rom_data_i[23:16], brightness_i), scl(rom_data_i[15:8], brightness_i),
                   scl(rom_data_i[7:0], brightness_i)};
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness_i;
  assign scaled = rom_data_i;
`endif
  always_comb begin
    prod = (THETA_BITS+COL_W)'(theta_i) << COL_W;
    col_d = frame_start_i ? COL_W'(prod >> THETA_BITS) + col_offset_i : col_q;
    rev_wrap = rev_q == RC_W'(FRAME_DIV-1);
    rev_d = !rev_pulse_i ? rev_q : rev_wrap ? '0 : rev_q + 1'b1;
    frame_d = !(rev_pulse_i && rev_wrap) ? frame_q
            : frame_q == FI_W'(NUM_FRAMES-1) ? '0 : frame_q + 1'b1;
    oob_c = {1'b0, px_idx_i} >= (PX_W+1)'(LED_COUNT);
    idx_c = oob_c ? PX_W'(LED_COUNT-1) : px_idx_i;
    // col_d, not col_q: a request coinciding with frame_start sees the new column
    addr_d = px_req_i ? ADDR_W'(frame_q) * FRAME_SZ + (ADDR_W'(idx_c) << COL_W) + ADDR_W'(col_d) : addr_q;
    data_d = v2_q ? (oob2_q ? '0 : scaled) : data_q;
  end
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      col_q <= '0;
      rev_q <= '0;
      frame_q <= '0;
      addr_q <= '0;
      v1_q <= 1'b0;
      oob1_q <= 1'b0;
      v2_q <= 1'b0;
      oob2_q <= 1'b0;
      valid_q <= 1'b0;
      data_q <= '0;
    end else begin
      col_q <= col_d;
      rev_q <= rev_d;
      frame_q <= frame_d;
      addr_q <= addr_d;
      v1_q <= px_req_i;
      oob1_q <= oob_c;
      v2_q <= v1_q;
      oob2_q <= oob1_q;
      valid_q <= v2_q;
      data_q <= data_d;
    end
  end
  assign rom_addr_o = addr_q;
  assign px_valid_o = valid_q;
  assign px_data_o = data_q;
  assign frame_idx_o = frame_q;
endmodule

// File: tb/tb_pov_column_fetcher.sv
// tb_pov_column_fetcher: directed stimulus with a scoreboard of expected pixels and arrival cycles.
module tb_pov_column_fetcher;
  localparam int LC = 52, TW = 256, TB = 6, NF = 4, FD = 8;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [5:0] theta = '0, px_idx = '0;
  logic rev_pulse = 1'b0, frame_start = 1'b0, px_req = 1'b0;
  logic [7:0] col_offset = '0, brightness = 8'd255;
  logic [15:0] rom_addr;
  logic [23:0] rom_data = '0, px_data;
  logic px_valid;
  logic [1:0] frame_idx;
  typedef struct { logic [23:0] d; int c; } exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0, passes = 0, cyc = 0;
  int col_m = 0, rev_m = 0, frame_m = 0;
  logic rom_ovr = 1'b0;
  pov_column_fetcher #(.LED_COUNT(LC), .TEX_WIDTH(TW), .THETA_BITS(TB), .NUM_FRAMES(NF), .FRAME_DIV(FD)) dut (
    .clk_i(clk), .reset_ni(reset_n), .theta_i(theta), .rev_pulse_i(rev_pulse),
    .frame_start_i(frame_start), .px_req_i(px_req), .px_idx_i(px_idx), .col_offset_i(col_offset),
    .brightness_i(brightness), .rom_addr_o(rom_addr), .rom_data_i(rom_data), .px_valid_o(px_valid),
    .px_data_o(px_data), .frame_idx_o(frame_idx)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  function automatic logic [23:0] rom_fn(input logic [15:0] a);
    return rom_ovr ? 24'hFF8040 : {a[7:0] ^ 8'hA5, a[15:8] ^ 8'h3C, a[7:0] + 8'h11};
  endfunction
  always @(posedge clk) rom_data <= rom_fn(rom_addr);
  function automatic logic [23:0] scale(input logic [23:0] p, input logic [7:0] b);
`ifdef POV_BRIGHTNESS_EN
    logic [23:0] r;
    for (int i = 0; i < 3; i++) r[i*8 +: 8] = 8'((int'(p[i*8 +: 8]) * (int'(b) + 1)) >> 8);
    return r;
`else
    return p;
`endif
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  always @(negedge clk) if (px_valid) begin
    if (q.size() == 0) chk("spurious_px_valid", 32'(px_valid), 0);
    else begin
      e = q.pop_front();
      chk("px_data", 32'(px_data), 32'(e.d));
      chk("px_valid_cycle", cyc, e.c);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drain();
    repeat (6) tick();
  endtask
  task automatic model_rev();
    if (rev_m == FD-1) begin
      rev_m = 0;
      frame_m = (frame_m + 1) % NF;
    end else rev_m++;
  endtask
  task automatic rev(input int n);
    repeat (n) begin
      rev_pulse = 1'b1;
      tick();
      rev_pulse = 1'b0;
      model_rev();
    end
  endtask
  task automatic fstart(input int th, input int off);
    theta = 6'(th);
    col_offset = 8'(off);
    frame_start = 1'b1;
    col_m = (((th * TW) >> TB) + off) % TW;
    tick();
    frame_start = 1'b0;
  endtask
  task automatic req(input int idx);
    int a;
    exp_t x;
    a = frame_m*LC*TW + (idx >= LC ? LC-1 : idx)*TW + col_m;
    px_req = 1'b1;
    px_idx = 6'(idx);
    x.d = idx >= LC ? 24'h0 : scale(rom_fn(16'(a)), brightness);
    x.c = cyc + 3;
    q.push_back(x);
    tick();
    px_req = 1'b0;
    frame_start = 1'b0;
    rev_pulse = 1'b0;
    chk("rom_addr", 32'(rom_addr), a);
  endtask
  initial begin
    repeat (3) tick();
    chk("reset_rom_addr", 32'(rom_addr), 0);
    chk("reset_px_valid", 32'(px_valid), 0);
    chk("reset_px_data", 32'(px_data), 0);
    chk("reset_frame_idx", 32'(frame_idx), 0);
    reset_n = 1'b1;
    tick();
    fstart(16, 0);
    req(3);
    drain();
    chk("px_data_hold", 32'(px_data), 32'(rom_fn(16'd832)));
    fstart(16, 200);
    req(0);
    theta = 6'd40;
    req(1);
    drain();
    fstart(0, 0);
    rev(8);
    chk("frame_idx_after_8", 32'(frame_idx), 1);
    req(0);
    rev(7);
    rev_pulse = 1'b1;
    req(2);
    model_rev();
    chk("frame_idx_after_16", 32'(frame_idx), 2);
    rev(16);
    chk("frame_idx_wrap", 32'(frame_idx), 0);
    theta = 6'd32;
    col_offset = 8'd0;
    frame_start = 1'b1;
    col_m = 128;
    req(5);
    drain();
    fstart(16, 0);
    for (int i = 0; i < LC; i++) req(i);
    req(60);
    drain();
    rom_ovr = 1'b1;
    brightness = 8'd127;
    req(0);
    drain();
    brightness = 8'd255;
    req(1);
    drain();
    brightness = 8'd0;
    req(2);
    drain();
    rom_ovr = 1'b0;
    brightness = 8'd255;
    rev(8);
    chk("frame_idx_pre_reset", 32'(frame_idx), 1);
    req(4);
    req(5);
    reset_n = 1'b0;
    q.delete();
    col_m = 0;
    rev_m = 0;
    frame_m = 0;
    tick();
    chk("midreset_frame_idx", 32'(frame_idx), 0);
    chk("midreset_rom_addr", 32'(rom_addr), 0);
    reset_n = 1'b1;
    drain();
    req(7);
    drain();
    chk("pending_pixels", q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
